// File: rtl/misr_mc_pkg.sv
// Shared constants and enums for the multi-channel MISR peripheral.
// Register offsets are byte offsets within a 0x100-byte block.
package misr_mc_pkg;

   localparam logic [7:0] OFF_CONTROL = 8'h00;
   localparam logic [7:0] OFF_LIMIT   = 8'h40;
   localparam logic [7:0] OFF_STATUS  = 8'h80;
   localparam logic [7:0] OFF_COUNT   = 8'hC0;

   localparam int unsigned CH_STRIDE = 256;
   localparam logic [7:0] CH_COEFF = 8'h00;
   localparam logic [7:0] CH_SIG   = 8'h40;
   localparam logic [7:0] CH_MODE  = 8'h80;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} misr_state_e;

   typedef enum logic [1:0] {
      MODE_DATA = 2'd0,
      MODE_ADDR = 2'd1,
      MODE_XOR  = 2'd2,
      MODE_RSVD = 2'd3
   } misr_mode_e;

endpackage

// File: rtl/misr_periph_mc_if.sv
// Simple re/we bus shared with the SRAM; the peripheral sits on the slave side.
interface misr_periph_mc_if #(
   parameter int NBIT_DATA = 64,
   parameter int NBIT_ADDR = 64
);
   logic                 re_i;
   logic                 we_i;
   logic [NBIT_ADDR-1:0] addr_i;
   logic [NBIT_DATA-1:0] data_i;
   logic [NBIT_DATA-1:0] data_o;

   modport master (output re_i, we_i, addr_i, data_i, input data_o);
   modport slave  (input re_i, we_i, addr_i, data_i, output data_o);
endinterface

// File: rtl/misr_periph_mc_channel.sv
// One MISR channel: coeff/seed/signature/mode registers and the compaction step.
// Write enables arrive already gated by the top-level FSM.
module misr_channel
   import misr_mc_pkg::*;
#(
   parameter int NBIT_REGS = 64,
   parameter int NBIT_DATA = 64,
   parameter int NBIT_ADDR = 64
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clr_i,
   input  logic                 step_i,
   input  logic                 wr_coeff_i,
   input  logic                 wr_sig_i,
   input  logic                 wr_mode_i,
   input  logic [NBIT_DATA-1:0] wdata_i,
   input  logic [NBIT_DATA-1:0] data_i,
   input  logic [NBIT_ADDR-1:0] addr_i,
   output logic [NBIT_REGS-1:0] coeff_o,
   output logic [NBIT_REGS-1:0] sig_o,
   output logic [1:0]           mode_o
);
   logic [NBIT_REGS-1:0] coeff_q, seed_q, sig_q, sig_d, in_w;
   misr_mode_e           mode_q;

   always_comb begin
      in_w = data_i[NBIT_REGS-1:0];
      case (mode_q)
         MODE_ADDR: in_w = addr_i[NBIT_REGS-1:0];
         MODE_XOR:  in_w = data_i[NBIT_REGS-1:0] ^ addr_i[NBIT_REGS-1:0];
         default:   in_w = data_i[NBIT_REGS-1:0];
      endcase
   end

   assign sig_d = {sig_q[NBIT_REGS-2:0], 1'b0} ^ (sig_q[NBIT_REGS-1] ? coeff_q : '0) ^ in_w;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         coeff_q <= '0;
         seed_q  <= '0;
         sig_q   <= '0;
         mode_q  <= MODE_DATA;
      end else begin
         if (clr_i)         sig_q <= seed_q;
         else if (wr_sig_i) begin
            seed_q <= wdata_i[NBIT_REGS-1:0];
            sig_q  <= wdata_i[NBIT_REGS-1:0];
         end else if (step_i) sig_q <= sig_d;
         if (wr_coeff_i) coeff_q <= wdata_i[NBIT_REGS-1:0];
         if (wr_mode_i)  mode_q  <= misr_mode_e'(wdata_i[1:0]);
      end
   end

   assign coeff_o = coeff_q;
   assign sig_o   = sig_q;
   assign mode_o  = mode_q;
endmodule

// File: rtl/misr_periph_mc.sv
// Multi-channel memory-mapped MISR: snoops out-of-window bus traffic into NUM_CH signatures.
// Define MISR_MC_IRQ_EN to add the irq_o port and the CONTROL irq-enable bit.
module misr_periph_mc
   import misr_mc_pkg::*;
#(
   parameter int                   NBIT_DATA  = 64,
   parameter int                   NBIT_ADDR  = 64,
   parameter int                   NBIT_REGS  = 64,
   parameter logic [NBIT_ADDR-1:0] START_ADDR = NBIT_ADDR'(2**25),
   parameter int                   NUM_CH     = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   misr_periph_mc_if.slave bus
`ifdef MISR_MC_IRQ_EN
   , output logic irq_o
`endif
);
   localparam logic [NBIT_ADDR-1:0] WIN_SIZE = NBIT_ADDR'(CH_STRIDE * (NUM_CH + 1));

   misr_state_e          state_q;
   logic                 en_q;
   logic [NUM_CH-1:0]    mask_q, run_mask_q;
   logic [NBIT_DATA-1:0] limit_q, count_q, data_q, rd_val;
   logic [NBIT_ADDR-1:0] off;
   logic [3:0]           blk;
   logic [7:0]           sub;
   logic                 in_win, evt, g_wr, wr_ctrl, wr_limit;

   logic [NUM_CH-1:0][NBIT_REGS-1:0] coeff_w, sig_w;
   logic [NUM_CH-1:0][1:0]           mode_w;
   logic [NUM_CH-1:0]                ch_wr, step_w;

`ifdef MISR_MC_IRQ_EN
   logic irq_en_q, irq_q;
   assign irq_o = irq_q;
`else
   logic irq_en_q;
   assign irq_en_q = 1'b0;
`endif

   assign off      = bus.addr_i - START_ADDR;
   assign in_win   = (bus.addr_i >= START_ADDR) && (off < WIN_SIZE);
   assign blk      = off[11:8];
   assign sub      = off[7:0];
   assign evt      = (bus.re_i | bus.we_i) & ~in_win;
   assign g_wr     = bus.we_i & in_win & (blk == 4'd0);
   assign wr_ctrl  = g_wr & (sub == OFF_CONTROL);
   assign wr_limit = g_wr & (sub == OFF_LIMIT) & (state_q != ST_RUN);

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign ch_wr[c]  = bus.we_i & in_win & (blk == 4'(c + 1)) & (state_q != ST_RUN);
      assign step_w[c] = evt & (state_q == ST_RUN) & run_mask_q[c];
      misr_channel #(
         .NBIT_REGS(NBIT_REGS), .NBIT_DATA(NBIT_DATA), .NBIT_ADDR(NBIT_ADDR)
      ) u_ch (
         .clk_i      (clk_i),
         .rst_ni     (rst_ni),
         .clr_i      (wr_ctrl & bus.data_i[1]),
         .step_i     (step_w[c]),
         .wr_coeff_i (ch_wr[c] & (sub == CH_COEFF)),
         .wr_sig_i   (ch_wr[c] & (sub == CH_SIG)),
         .wr_mode_i  (ch_wr[c] & (sub == CH_MODE)),
         .wdata_i    (bus.data_i),
         .data_i     (bus.data_i),
         .addr_i     (bus.addr_i),
         .coeff_o    (coeff_w[c]),
         .sig_o      (sig_w[c]),
         .mode_o     (mode_w[c])
      );
   end

   always_comb begin
      rd_val = '0;
      if (in_win && blk == 4'd0) begin
         case (sub)
            OFF_CONTROL: rd_val = NBIT_DATA'({irq_en_q, mask_q, 1'b0, en_q});
            OFF_LIMIT:   rd_val = limit_q;
            OFF_STATUS:  rd_val = NBIT_DATA'({state_q == ST_RUN,
                                               (state_q == ST_DONE) ? run_mask_q : '0});
            OFF_COUNT:   rd_val = count_q;
            default:     rd_val = '0;
         endcase
      end
      for (int c = 0; c < NUM_CH; c++) begin
         if (in_win && blk == 4'(c + 1)) begin
            case (sub)
               CH_COEFF: rd_val = NBIT_DATA'(coeff_w[c]);
               CH_SIG:   rd_val = NBIT_DATA'(sig_w[c]);
               CH_MODE:  rd_val = NBIT_DATA'(mode_w[c]);
               default:  rd_val = '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         en_q       <= 1'b0;
         mask_q     <= '0;
         run_mask_q <= '0;
         limit_q    <= '0;
         count_q    <= '0;
         data_q     <= '0;
`ifdef MISR_MC_IRQ_EN
         irq_en_q   <= 1'b0;
         irq_q      <= 1'b0;
`endif
      end else begin
         if (bus.re_i) data_q <= rd_val;
         if (wr_limit) limit_q <= bus.data_i;
         if (wr_ctrl) begin
            en_q   <= bus.data_i[0];
            mask_q <= bus.data_i[2 +: NUM_CH];
`ifdef MISR_MC_IRQ_EN
            irq_en_q <= bus.data_i[2 + NUM_CH];
`endif
         end
`ifdef MISR_MC_IRQ_EN
         irq_q <= (state_q == ST_DONE) & irq_en_q;
`endif
         // Soft clear wins over enable; CONTROL writes never coincide with events.
         if (wr_ctrl && bus.data_i[1]) begin
            state_q <= ST_IDLE;
            count_q <= '0;
         end else if (wr_ctrl && !bus.data_i[0]) begin
            state_q <= ST_IDLE;
         end else begin
            case (state_q)
               ST_IDLE: if (wr_ctrl && |bus.data_i[2 +: NUM_CH]) begin
                  state_q    <= ST_RUN;
                  run_mask_q <= bus.data_i[2 +: NUM_CH];
               end
               ST_RUN: if (evt) begin
                  if (count_q != '1) count_q <= count_q + 1'b1;
                  if (limit_q != '0 && count_q == limit_q - 1'b1) state_q <= ST_DONE;
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.data_o = data_q;
endmodule
